// File: rtl/multi_channel_trigger_if.sv
// Sample bus into the coincidence trigger and the event status it reports back.
// LEN_W must equal clog2(MAX_EVENT+1) of the attached trigger.
interface multi_channel_trigger_if #(
  parameter int N_CH  = 4,
  parameter int E_W   = 64,
  parameter int LEN_W = 13
);
  logic                 init_done;
  logic                 sample_valid;
  logic [N_CH*E_W-1:0]  energy;
  logic [N_CH*E_W-1:0]  th;
  logic                 event_detected;
  logic                 freeze;
  logic                 event_start;
  logic                 event_end;
  logic                 timeout;
  logic [N_CH-1:0]      ch_active;
  logic [LEN_W-1:0]     event_len;

  modport master (
    output init_done, sample_valid, energy, th,
    input  event_detected, freeze, event_start, event_end, timeout, ch_active, event_len
  );

  modport slave (
    input  init_done, sample_valid, energy, th,
    output event_detected, freeze, event_start, event_end, timeout, ch_active, event_len
  );
endinterface

// File: rtl/multi_channel_trigger.sv
// Short/long energy ratio trigger with channel voting, pre-trigger qualification,
// hang-over release and an event length limit.
//
// state   | meaning
// INIT    | front end not ready, init_done awaited
// IDLE    | waiting for a qualifying sample (only when armed)
// PRETRIG | counting consecutive qualifying samples
// EVENT   | event running, sustain condition met
// HANG    | event running, tolerating non-sustaining samples
module multi_channel_trigger #(
  parameter int N_CH       = 4,
  parameter int E_W        = 64,
  parameter int SHORT_SIZE = 15,
  parameter int LONG_SIZE  = 31,
  parameter int ON_FACTOR  = 5,
  parameter int OFF_FACTOR = 3,
  parameter int TRIG_COUNT = 2,
  parameter int HANG_COUNT = 3,
  parameter int VOTE       = 2,
  parameter int MAX_EVENT  = 4096,
  parameter int LEN_W      = $clog2(MAX_EVENT + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  multi_channel_trigger_if.slave   bus
);
  localparam int PW = E_W + 16;
  localparam int TW = $clog2(TRIG_COUNT + 1);
  localparam int HW = (HANG_COUNT > 0) ? $clog2(HANG_COUNT + 1) : 1;
  localparam logic signed [PW-1:0] K_LONG = PW'(LONG_SIZE);
  localparam logic signed [PW-1:0] K_ON   = PW'(ON_FACTOR * SHORT_SIZE);
  localparam logic signed [PW-1:0] K_OFF  = PW'(OFF_FACTOR * SHORT_SIZE);
  localparam logic [LEN_W-1:0]     LEN_MAX = LEN_W'(MAX_EVENT);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_PRETRIG, S_EVENT, S_HANG} state_t;

  state_t            state, state_n;
  logic [TW-1:0]     trem, trem_n;
  logic [HW-1:0]     hrem, hrem_n;
  logic [LEN_W-1:0]  len, len_n, len_inc;
  logic [N_CH-1:0]   act, act_n;
  logic              armed, armed_n;
  logic              tmo, tmo_n;
  logic              start, start_n;
  logic              endp, endp_n;
  logic [N_CH-1:0]   on, sus;
  logic              qual, sustain;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic signed [PW-1:0] e_x, t_x;
    assign e_x   = {{(PW-E_W){bus.energy[i*E_W+E_W-1]}}, bus.energy[i*E_W +: E_W]};
    assign t_x   = {{(PW-E_W){bus.th[i*E_W+E_W-1]}}, bus.th[i*E_W +: E_W]};
    assign on[i]  = (e_x * K_LONG) > (t_x * K_ON);
    assign sus[i] = !((e_x * K_LONG) < (t_x * K_OFF));
  end

  assign qual    = $countones(on) >= VOTE;
  assign sustain = $countones(sus) >= VOTE;
  assign len_inc = (len == LEN_MAX) ? len : len + LEN_W'(1);

  // Remaining-count timers: trem counts qualifying samples still needed,
  // hrem counts non-sustaining samples still tolerated in HANG.
  always_comb begin
    state_n = state;
    trem_n  = trem;
    hrem_n  = hrem;
    len_n   = len;
    act_n   = act;
    armed_n = armed;
    tmo_n   = tmo;
    start_n = 1'b0;
    endp_n  = 1'b0;
    if (bus.sample_valid) begin
      if (state != S_INIT) act_n = on;
      if (!qual) armed_n = 1'b1;
      case (state)
        S_INIT: if (bus.init_done) state_n = S_IDLE;
        S_IDLE: begin
          if (qual && armed) begin
            if (TRIG_COUNT == 1) begin
              state_n = S_EVENT;
              start_n = 1'b1;
              len_n   = LEN_W'(1);
              tmo_n   = 1'b0;
            end else begin
              state_n = S_PRETRIG;
              trem_n  = TW'(TRIG_COUNT - 1);
            end
          end
        end
        S_PRETRIG: begin
          if (!qual) begin
            state_n = S_IDLE;
            trem_n  = '0;
          end else if (trem == TW'(1)) begin
            state_n = S_EVENT;
            trem_n  = '0;
            start_n = 1'b1;
            len_n   = LEN_W'(1);
            tmo_n   = 1'b0;
          end else begin
            trem_n = trem - TW'(1);
          end
        end
        S_EVENT, S_HANG: begin
          len_n = len_inc;
          if (len_inc == LEN_MAX) begin
            state_n = S_IDLE;
            hrem_n  = '0;
            endp_n  = 1'b1;
            tmo_n   = 1'b1;
            armed_n = 1'b0;
          end else if (state == S_EVENT) begin
            if (!sustain) begin
              if (HANG_COUNT > 0) begin
                state_n = S_HANG;
                hrem_n  = HW'(HANG_COUNT - 1);
              end else begin
                state_n = S_IDLE;
                endp_n  = 1'b1;
              end
            end
          end else if (sustain) begin
            state_n = S_EVENT;
            hrem_n  = '0;
          end else if (hrem == '0) begin
            state_n = S_IDLE;
            endp_n  = 1'b1;
          end else begin
            hrem_n = hrem - HW'(1);
          end
        end
        default: state_n = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_INIT;
      trem  <= '0;
      hrem  <= '0;
      len   <= '0;
      act   <= '0;
      armed <= 1'b1;
      tmo   <= 1'b0;
      start <= 1'b0;
      endp  <= 1'b0;
    end else begin
      state <= state_n;
      trem  <= trem_n;
      hrem  <= hrem_n;
      len   <= len_n;
      act   <= act_n;
      armed <= armed_n;
      tmo   <= tmo_n;
      start <= start_n;
      endp  <= endp_n;
    end
  end

  assign bus.event_detected = (state == S_EVENT) || (state == S_HANG);
  assign bus.freeze         = (state == S_PRETRIG) || (state == S_EVENT) || (state == S_HANG);
  assign bus.event_start    = start;
  assign bus.event_end      = endp;
  assign bus.timeout        = tmo;
  assign bus.ch_active      = act;
  assign bus.event_len      = len;
endmodule

// File: tb/tb_multi_channel_trigger.sv
// Scenario bench for multi_channel_trigger with MAX_EVENT=16 and all thresholds at 100.
// Expected output words are queued per sample and compared once the test has run.
module tb_multi_channel_trigger;
  localparam int N_CH  = 4;
  localparam int E_W   = 64;
  localparam int MAXE  = 16;
  localparam int LEN_W = 5;
  localparam int OW    = 5 + LEN_W + N_CH;

  typedef struct {
    logic [OW-1:0] v;
    logic [OW-1:0] m;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [OW-1:0] obs_q[$];

  multi_channel_trigger_if #(.N_CH(N_CH), .E_W(E_W), .LEN_W(LEN_W)) bus ();

  multi_channel_trigger #(.N_CH(N_CH), .E_W(E_W), .MAX_EVENT(MAXE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [OW-1:0] obs();
    return {bus.event_detected, bus.freeze, bus.event_start, bus.event_end,
            bus.timeout, bus.event_len, bus.ch_active};
  endfunction

  // act < 0 leaves ch_active unchecked for that sample.
  task automatic step(input int e0, e1, e2, e3, input bit v, input bit init,
                      input int det, frz, st, en, tmo, len, act);
    exp_t x;
    bus.energy       = {E_W'(e3), E_W'(e2), E_W'(e1), E_W'(e0)};
    bus.sample_valid = v;
    bus.init_done    = init;
    x.v = {det[0], frz[0], st[0], en[0], tmo[0], len[LEN_W-1:0], act[N_CH-1:0]};
    x.m = (act < 0) ? {{(OW-N_CH){1'b1}}, {N_CH{1'b0}}} : {OW{1'b1}};
    exp_q.push_back(x);
    @(posedge clock);
    @(negedge clock);
    obs_q.push_back(obs());
  endtask

  task automatic test_reset();
    bus.init_done    = 1'b1;
    bus.sample_valid = 1'b1;
    bus.energy       = {4{E_W'(300)}};
    bus.th           = {4{E_W'(100)}};
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL reset outputs: got %h want 0", obs());
    end
    reset = 1'b0;
  endtask

  task automatic test_init();
    exp_t e;
    logic [OW-1:0] o;
    int idx = 0;
    for (int i = 0; i < 10; i++) step(300, 300, 300, 300, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(300, 300, 300, 300, 1, 1, 0, 0, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        failures++; $display("FAIL init step %0d: got %h want %h", idx, o, e.v);
      end
      idx++;
    end
  endtask

  task automatic test_trigger();
    exp_t e;
    logic [OW-1:0] o;
    int idx = 0;
    step(300, 300, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3);
    step(300, 300, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 3);
    step(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 4, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 5, 0);
    step(300, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1);
    step(300, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        failures++; $display("FAIL trigger step %0d: got %h want %h", idx, o, e.v);
      end
      idx++;
    end
  endtask

  task automatic test_pretrig_abort();
    exp_t e;
    logic [OW-1:0] o;
    int idx = 0;
    step(300, 300, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5, 3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 3);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        failures++; $display("FAIL pretrig_abort step %0d: got %h want %h", idx, o, e.v);
      end
      idx++;
    end
  endtask

  task automatic test_hang();
    exp_t e;
    logic [OW-1:0] o;
    int idx = 0;
    step(300, 300, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5, 3);
    step(300, 300, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 3);
    step(100, 100, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2, 0);
    step(100, 100, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3, 0);
    step(300, 300, 0, 0, 1, 0, 1, 1, 0, 0, 0, 4, 3);
    for (int k = 5; k <= 7; k++) step(100, 100, 0, 0, 1, 0, 1, 1, 0, 0, 0, k, 0);
    step(100, 100, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        failures++; $display("FAIL hang step %0d: got %h want %h", idx, o, e.v);
      end
      idx++;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [OW-1:0] o;
    int idx = 0;
    step(300, 300, 0, 0, 1, 0, 0, 1, 0, 0, 0, 8, 3);
    step(300, 300, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 3);
    for (int k = 2; k < MAXE; k++) step(300, 300, 0, 0, 1, 0, 1, 1, 0, 0, 0, k, 3);
    step(300, 300, 0, 0, 1, 0, 0, 0, 0, 1, 1, MAXE, 3);
    for (int k = 0; k < 3; k++) step(300, 300, 0, 0, 1, 0, 0, 0, 0, 0, 1, MAXE, 3);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, MAXE, 0);
    step(300, 300, 0, 0, 1, 0, 0, 1, 0, 0, 1, MAXE, 3);
    step(300, 300, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 3);
    for (int k = 2; k <= 4; k++) step(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, k, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 5, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        failures++; $display("FAIL timeout step %0d: got %h want %h", idx, o, e.v);
      end
      idx++;
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    logic [OW-1:0] o;
    int idx = 0;
    step(241, 241, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    step(241, 241, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    step(242, 242, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5, 3);
    step(242, 242, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 3);
    for (int k = 2; k <= 5; k++) step(146, 146, 0, 0, 1, 0, 1, 1, 0, 0, 0, k, 0);
    for (int k = 6; k <= 8; k++) step(145, 145, 0, 0, 1, 0, 1, 1, 0, 0, 0, k, 0);
    step(145, 145, 0, 0, 1, 0, 0, 0, 0, 1, 0, 9, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        failures++; $display("FAIL boundary step %0d: got %h want %h", idx, o, e.v);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid_event();
    exp_t e;
    logic [OW-1:0] o;
    int idx = 0;
    step(300, 300, 0, 0, 1, 0, 0, 1, 0, 0, 0, 9, 3);
    step(300, 300, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 3);
    step(300, 300, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2, 3);
    bus.init_done = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (obs() !== '0) begin
      failures++; $display("FAIL reset_mid outputs: got %h want 0", obs());
    end
    reset = 1'b0;
    step(300, 300, 300, 300, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(300, 300, 300, 300, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(300, 300, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        failures++; $display("FAIL reset_mid step %0d: got %h want %h", idx, o, e.v);
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_trigger();
    test_pretrig_abort();
    test_hang();
    test_timeout();
    test_boundary();
    test_reset_mid_event();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_channel_trigger.md
MULTI_CHANNEL_TRIGGER -- requirements
Module: multi_channel_trigger

Interface
REQ-001 Parameter N_CH, default 4: number of energy channels (1..16).
REQ-002 Parameter E_W, default 64: signed width of each energy and threshold word.
REQ-003 Parameter SHORT_SIZE, default 15, and LONG_SIZE, default 31: short- and long-window lengths used in the ratio compare.
REQ-004 Parameter ON_FACTOR, default 5, and OFF_FACTOR, default 3: trigger and release ratio factors.
REQ-005 Parameter TRIG_COUNT, default 2: consecutive qualifying samples needed to declare an event (at least 1).
REQ-006 Parameter HANG_COUNT, default 3: consecutive non-sustaining samples tolerated before the event ends (0 = immediate).
REQ-007 Parameter VOTE, default 2: channel coincidence count (1..N_CH).
REQ-008 Parameter MAX_EVENT, default 4096: event length limit in samples; LEN_W = clog2(MAX_EVENT+1).
REQ-009 Ports: reset, synchronous, active-high; clock clock.
REQ-010 init_done  in  1  front-end initialisation complete.
REQ-011 sample_valid  in  1  energy/th carry a new sample this cycle.
REQ-012 energy  in  N_CH*E_W  signed short-window energies, channel i at bits [i*E_W +: E_W].
REQ-013 th  in  N_CH*E_W  signed long-window thresholds, same packing.
REQ-014 event_detected  out  1  event in progress (EVENT or HANG).
REQ-015 freeze  out  1  long-window update inhibit.
REQ-016 event_start / event_end  out  1 each  single-cycle pulses.
REQ-017 timeout  out  1  qualifies event_end; set when the event was ended by MAX_EVENT.
REQ-018 ch_active  out  N_CH  per-channel on-condition of the last valid sample.
REQ-019 event_len  out  LEN_W  valid samples in the current or last event.

Function
REQ-020 Per channel: on[i] = energy*LONG_SIZE > th*ON_FACTOR*SHORT_SIZE; sus[i] = NOT(energy*LONG_SIZE < th*OFF_FACTOR*SHORT_SIZE). Both are signed and evaluated at E_W+16 bits with no truncation.
REQ-021 qual = popcount(on) >= VOTE; sustain = popcount(sus) >= VOTE.
REQ-022 All outputs are registered, and the response appears one cycle after the valid sample. On cycles with sample_valid=0, state, counters and ch_active hold and pulses are 0.
REQ-023 States: INIT, IDLE, PRETRIG, EVENT, HANG.
REQ-024 INIT: go to IDLE when init_done=1; init_done is ignored in all other states.
REQ-025 IDLE (valid, qual, armed): if TRIG_COUNT=1, go to EVENT; otherwise go to PRETRIG with cnt=1.
REQ-026 PRETRIG (valid): if qual and cnt+1=TRIG_COUNT, go to EVENT; if qual otherwise, cnt++; if not qual, go to IDLE with cnt=0.
REQ-027 Entry to EVENT: event_start=1, event_len=1, timeout=0.
REQ-028 EVENT (valid): event_len++; if not sustain, go to HANG with hcnt=1 when HANG_COUNT>0, otherwise go to IDLE with event_end=1.
REQ-029 HANG (valid): event_len++; if sustain, go to EVENT with hcnt=0; else if hcnt=HANG_COUNT, go to IDLE with event_end=1; else hcnt++.
REQ-030 If event_len reaches MAX_EVENT in EVENT or HANG: go to IDLE with event_end=1, timeout=1, armed=0.
REQ-031 armed clears on timeout and sets on the first valid sample with qual=0. It is 1 after reset.
REQ-032 freeze=1 in PRETRIG, EVENT and HANG, and 0 in INIT and IDLE (freeze is non-sticky).
REQ-033 event_len saturates at MAX_EVENT and holds after event_end until the next event_start.
REQ-034 timeout holds until the next event_start.

Reset
REQ-035 On reset: state=INIT, cnt=hcnt=0, armed=1. All outputs are 0, including ch_active and event_len.
REQ-036 Reset wins over all inputs in the same cycle, including mid-event; no event_end pulse is generated.

Verification (defaults, MAX_EVENT=16, all th=100: on at energy>=242, release below at energy<=145)
REQ-037 Hold init_done=0 for 10 valid samples with energy=300 -> all outputs 0. Then raise init_done -> IDLE, no trigger on that cycle.
REQ-038 Drive ch0 and ch1 at 300 for 2 valid samples -> event_start pulses one cycle after the 2nd sample; event_detected=1, freeze=1, ch_active=4'b0011. The same stimulus on ch0 alone -> no event.
REQ-039 Drive two channels at 300 for 1 sample, then 0 -> PRETRIG then IDLE; freeze goes 1 then back to 0; no event_start.
REQ-040 In an event, drive 2 samples at 100, then 300 -> stays detected with no event_end. Then drive 100 on 4 samples -> event_end after the 4th sample, timeout=0, event_len equal to the count of valid samples.
REQ-041 Sustain two channels at 300 -> event_end with timeout=1 and event_len=16. Continued 300 -> no retrigger. One sample at 0, then 2 at 300 -> new event_start.
REQ-042 Boundary and reset: energy 242 on two channels triggers while 241 does not; energy 146 sustains while 145 releases. Reset asserted mid-event -> all outputs 0 next cycle and state INIT.
